rc4_encrypt_core: RTL and testbench

Single-key RC4 encryption engine: the transmit-side counterpart of the multicore RC4 cracking cores. Given a 24-bit secret key, it initialises and schedules its 256x8 working RAM (S), then streams a MSG_LEN-byte plaintext memory through the PRGA and writes ciphertext into a MSG_LEN x 8 RAM. It produces the encrypted-message images the cracker's E-ROM is loaded with, and provides on-chip known-answer material for cracker regression.

---
 rtl/rc4_encrypt_core.sv | 257 +++++++++++++++++++++++++
 tb/tb_rc4_encrypt_core.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rc4_encrypt_core.sv
// Single-key RC4 encryption engine: S-box init, key schedule, then PRGA over a MSG_LEN-byte message.
// Optional build macro RC4_ENC_KEY_MASK_EN clears secret_key[23:22] when the key is latched.
module rc4_encrypt_core #(
  parameter int MSG_LEN   = 32,
  parameter int KEY_BYTES = 3,
  localparam int AW       = $clog2(MSG_LEN)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [23:0]   secret_key,
  output logic          busy,
  output logic          done,
  output logic [7:0]    address_s,
  output logic [7:0]    data_s,
  output logic          wren_s,
  input  logic [7:0]    q_s,
  output logic [AW-1:0] address_p,
  input  logic [7:0]    q_p,
  output logic [AW-1:0] address_c,
  output logic [7:0]    data_c,
  output logic          wren_c
);

  typedef enum logic [3:0] {
    IDLE = 4'd0,  INIT = 4'd1,
    K_RD = 4'd2,  K_GI = 4'd3,  K_GJ = 4'd4,  K_WJ = 4'd5,  K_WI = 4'd6,
    P_RD = 4'd7,  P_GI = 4'd8,  P_GJ = 4'd9,  P_WJ = 4'd10, P_WI = 4'd11,
    P_RF = 4'd12, P_GF = 4'd13, DONE = 4'd14
  } state_t;

  localparam logic [AW-1:0] K_LAST   = AW'(MSG_LEN - 1);
  localparam logic [1:0]    IDX_LAST = 2'(KEY_BYTES - 1);

  state_t        state_r, state_n;
  logic [23:0]   key_r, key_n, key_in_s;
  logic [7:0]    i_r, i_n, j_r, j_n;
  logic [7:0]    si_r, si_n, sj_r, sj_n, p_r, p_n;
  logic [AW-1:0] k_r, k_n;
  logic [1:0]    key_idx_r, key_idx_n;
  logic [7:0]    key_byte_s, ksa_j_s, prga_j_s;

  logic          busy_r, busy_n, done_r, done_n;
  logic [7:0]    address_s_r, address_s_n, data_s_r, data_s_n;
  logic          wren_s_r, wren_s_n;
  logic [AW-1:0] address_p_r, address_p_n, address_c_r, address_c_n;
  logic [7:0]    data_c_r, data_c_n;
  logic          wren_c_r, wren_c_n;

`ifdef RC4_ENC_KEY_MASK_EN
  assign key_in_s = {2'b00, secret_key[21:0]};
`else
  assign key_in_s = secret_key;
`endif

  // Key byte for the current KSA step; byte 0 is the most significant key byte.
  always_comb begin
    case (key_idx_r)
      2'd0:    key_byte_s = key_r[23:16];
      2'd1:    key_byte_s = key_r[15:8];
      default: key_byte_s = key_r[7:0];
    endcase
  end

  assign ksa_j_s  = j_r + q_s + key_byte_s;
  assign prga_j_s = j_r + q_s;

  // Next-state and next-output logic; every output is registered from these values.
  always_comb begin
    state_n     = state_r;
    key_n       = key_r;
    i_n         = i_r;
    j_n         = j_r;
    si_n        = si_r;
    sj_n        = sj_r;
    p_n         = p_r;
    k_n         = k_r;
    key_idx_n   = key_idx_r;
    busy_n      = busy_r;
    done_n      = 1'b0;
    address_s_n = address_s_r;
    data_s_n    = data_s_r;
    wren_s_n    = 1'b0;
    address_p_n = address_p_r;
    address_c_n = address_c_r;
    data_c_n    = data_c_r;
    wren_c_n    = 1'b0;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_n     = INIT;
          key_n       = key_in_s;
          i_n         = 8'd0;
          j_n         = 8'd0;
          k_n         = '0;
          key_idx_n   = 2'd0;
          busy_n      = 1'b1;
          address_s_n = 8'd0;
          data_s_n    = 8'd0;
          wren_s_n    = 1'b1;
        end else begin
          state_n = IDLE;
        end
      end
      INIT: begin
        if (i_r == 8'd255) begin
          state_n     = K_RD;
          i_n         = 8'd0;
          j_n         = 8'd0;
          key_idx_n   = 2'd0;
          address_s_n = 8'd0;
        end else begin
          i_n         = i_r + 8'd1;
          address_s_n = i_r + 8'd1;
          data_s_n    = i_r + 8'd1;
          wren_s_n    = 1'b1;
        end
      end
      K_RD: state_n = K_GI;
      K_GI: begin
        state_n     = K_GJ;
        si_n        = q_s;
        j_n         = ksa_j_s;
        address_s_n = ksa_j_s;
      end
      // S[j] is captured before it is overwritten, so S[j]=si goes first, then S[i]=sj.
      K_GJ: begin
        state_n     = K_WJ;
        address_s_n = j_r;
        data_s_n    = si_r;
        wren_s_n    = 1'b1;
      end
      K_WJ: begin
        state_n     = K_WI;
        address_s_n = i_r;
        data_s_n    = q_s;
        wren_s_n    = 1'b1;
      end
      K_WI: begin
        key_idx_n = (key_idx_r == IDX_LAST) ? 2'd0 : key_idx_r + 2'd1;
        if (i_r == 8'd255) begin
          state_n     = P_RD;
          i_n         = 8'd1;
          j_n         = 8'd0;
          k_n         = '0;
          address_s_n = 8'd1;
          address_p_n = '0;
        end else begin
          state_n     = K_RD;
          i_n         = i_r + 8'd1;
          address_s_n = i_r + 8'd1;
        end
      end
      P_RD: state_n = P_GI;
      P_GI: begin
        state_n     = P_GJ;
        si_n        = q_s;
        p_n         = q_p;
        j_n         = prga_j_s;
        address_s_n = prga_j_s;
      end
      P_GJ: begin
        state_n     = P_WJ;
        address_s_n = j_r;
        data_s_n    = si_r;
        wren_s_n    = 1'b1;
      end
      P_WJ: begin
        state_n     = P_WI;
        sj_n        = q_s;
        address_s_n = i_r;
        data_s_n    = q_s;
        wren_s_n    = 1'b1;
      end
      P_WI: begin
        state_n     = P_RF;
        address_s_n = si_r + sj_r;
      end
      P_RF: state_n = P_GF;
      P_GF: begin
        address_c_n = k_r;
        data_c_n    = q_s ^ p_r;
        wren_c_n    = 1'b1;
        if (k_r == K_LAST) begin
          state_n = DONE;
          busy_n  = 1'b0;
          done_n  = 1'b1;
        end else begin
          state_n     = P_RD;
          k_n         = k_r + 1'b1;
          i_n         = i_r + 8'd1;
          address_s_n = i_r + 8'd1;
          address_p_n = k_r + 1'b1;
        end
      end
      DONE: state_n = IDLE;
      default: begin
        state_n = IDLE;
        busy_n  = 1'b0;
      end
    endcase
  end

  // State, datapath and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r     <= IDLE;
      key_r       <= 24'd0;
      i_r         <= 8'd0;
      j_r         <= 8'd0;
      si_r        <= 8'd0;
      sj_r        <= 8'd0;
      p_r         <= 8'd0;
      k_r         <= '0;
      key_idx_r   <= 2'd0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      address_s_r <= 8'd0;
      data_s_r    <= 8'd0;
      wren_s_r    <= 1'b0;
      address_p_r <= '0;
      address_c_r <= '0;
      data_c_r    <= 8'd0;
      wren_c_r    <= 1'b0;
    end else begin
      state_r     <= state_n;
      key_r       <= key_n;
      i_r         <= i_n;
      j_r         <= j_n;
      si_r        <= si_n;
      sj_r        <= sj_n;
      p_r         <= p_n;
      k_r         <= k_n;
      key_idx_r   <= key_idx_n;
      busy_r      <= busy_n;
      done_r      <= done_n;
      address_s_r <= address_s_n;
      data_s_r    <= data_s_n;
      wren_s_r    <= wren_s_n;
      address_p_r <= address_p_n;
      address_c_r <= address_c_n;
      data_c_r    <= data_c_n;
      wren_c_r    <= wren_c_n;
    end
  end

  assign busy      = busy_r;
  assign done      = done_r;
  assign address_s = address_s_r;
  assign data_s    = data_s_r;
  assign wren_s    = wren_s_r;
  assign address_p = address_p_r;
  assign address_c = address_c_r;
  assign data_c    = data_c_r;
  assign wren_c    = wren_c_r;

endmodule

// File: tb/tb_rc4_encrypt_core.sv
// Self-checking bench for rc4_encrypt_core: memory models, array-based RC4 reference, vector table.
module tb_rc4_encrypt_core;
  localparam int MSG_LEN = 32;
  localparam int AW      = 5;
  localparam int T_DONE  = 1536 + 7 * MSG_LEN;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [23:0]   secret_key = 24'd0;
  logic          busy, done, wren_s, wren_c;
  logic [7:0]    address_s, data_s, q_s, q_p, data_c;
  logic [AW-1:0] address_p, address_c;

  logic [7:0] s_mem [256];
  logic [7:0] p_mem [MSG_LEN];
  logic [7:0] c_mem [MSG_LEN];
  int m_s  [256];
  int m_ct [MSG_LEN];
  int prev_ct [MSG_LEN];

  int cyc = 0;
  int wc_total = 0, wc_addr_err = 0, ws_total = 0;
  int n_checks = 0, n_errors = 0;

  typedef struct {
    logic [23:0] key;
    bit          new_pt;
    bit          kat;
    logic [71:0] pt_head;
    logic [71:0] ct_head;
  } vec_t;
  vec_t tbl [5];

  rc4_encrypt_core #(.MSG_LEN(MSG_LEN), .KEY_BYTES(3)) dut (
    .clk(clk), .rst(rst), .start(start), .secret_key(secret_key),
    .busy(busy), .done(done),
    .address_s(address_s), .data_s(data_s), .wren_s(wren_s), .q_s(q_s),
    .address_p(address_p), .q_p(q_p),
    .address_c(address_c), .data_c(data_c), .wren_c(wren_c)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Single-port memories with registered address and one-cycle read latency.
  always @(posedge clk) begin
    if (wren_s) s_mem[address_s] <= data_s;
    q_s <= s_mem[address_s];
    q_p <= p_mem[address_p];
    if (wren_c) c_mem[address_c] <= data_c;
  end

  // Write-strobe bookkeeping; ciphertext addresses must run 0..MSG_LEN-1 in order.
  always @(negedge clk) begin
    if (wren_c) begin
      wc_total <= wc_total + 1;
      if (address_c != wc_total[AW-1:0]) wc_addr_err <= wc_addr_err + 1;
    end
    if (wren_s) ws_total <= ws_total + 1;
  end

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Plain-array RC4 over the current plaintext memory.
  task automatic model_run(input logic [23:0] key_in);
    logic [23:0] key;
    int kb [3];
    int i, j, t;
    key = key_in;
`ifdef RC4_ENC_KEY_MASK_EN
    key[23:22] = 2'b00;
`endif
    kb[0] = int'(key[23:16]);
    kb[1] = int'(key[15:8]);
    kb[2] = int'(key[7:0]);
    for (int a = 0; a < 256; a++) m_s[a] = a;
    j = 0;
    for (int a = 0; a < 256; a++) begin
      j = (j + m_s[a] + kb[a % 3]) % 256;
      t = m_s[a]; m_s[a] = m_s[j]; m_s[j] = t;
    end
    i = 0;
    j = 0;
    for (int k = 0; k < MSG_LEN; k++) begin
      i = (i + 1) % 256;
      j = (j + m_s[i]) % 256;
      t = m_s[i]; m_s[i] = m_s[j]; m_s[j] = t;
      m_ct[k] = int'(p_mem[k]) ^ m_s[(m_s[i] + m_s[j]) % 256];
    end
  endtask

  task automatic accept(input logic [23:0] key, output int e0);
    @(negedge clk);
    secret_key = key;
    start = 1'b1;
    @(negedge clk);
    e0 = cyc;
    check("busy_after_accept", longint'(busy), 1);
  endtask

  task automatic wait_done(input int e0, input bit toggle, output int dcyc);
    dcyc = -1;
    for (int w = 0; w < 3000 && dcyc < 0; w++) begin
      if (toggle) start = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (done === 1'b1) dcyc = cyc;
    end
    if (toggle) start = 1'b0;
    check("done_latency", longint'(dcyc - e0), T_DONE);
    check("busy_low_at_done", longint'(busy), 0);
  endtask

  task automatic verify(input int wc0, input int ws0);
    int bad, dup;
    bit seen [256];
    for (int k = 0; k < MSG_LEN; k++)
      check($sformatf("ct_byte_%0d", k), longint'(c_mem[k]), longint'(m_ct[k]));
    bad = 0;
    dup = 0;
    for (int a = 0; a < 256; a++) seen[a] = 1'b0;
    for (int a = 0; a < 256; a++) begin
      if (int'(s_mem[a]) != m_s[a]) bad++;
      if (seen[s_mem[a]]) dup++;
      seen[s_mem[a]] = 1'b1;
    end
    check("s_final_vs_model", longint'(bad), 0);
    check("s_is_permutation", longint'(dup), 0);
    check("wren_c_pulses", longint'(wc_total - wc0), MSG_LEN);
    check("address_c_order", longint'(wc_addr_err), 0);
    check("wren_s_pulses", longint'(ws_total - ws0), 256 + 512 + 2 * MSG_LEN);
  endtask

  task automatic run_full(input logic [23:0] key, input bit toggle);
    int e0, dcyc, wc0, ws0;
    wc0 = wc_total;
    ws0 = ws_total;
    model_run(key);
    accept(key, e0);
    start = 1'b0;
    secret_key = 24'($urandom);
    wait_done(e0, toggle, dcyc);
    @(negedge clk);
    check("done_one_cycle", longint'(done), 0);
    verify(wc0, ws0);
    repeat (3) @(negedge clk);
    check("no_reaccept", longint'({busy, done}), 0);
  endtask

  task automatic check_kat(input logic [71:0] ct_head);
`ifndef RC4_ENC_KEY_MASK_EN
    for (int b = 0; b < 9; b++)
      check($sformatf("kat_byte_%0d", b), longint'(c_mem[b]), longint'(ct_head[8*(8-b) +: 8]));
`endif
  endtask

  task automatic load_pt(input vec_t v);
    if (v.kat) begin
      for (int k = 0; k < MSG_LEN; k++) p_mem[k] = 8'd0;
      for (int b = 0; b < 9; b++) p_mem[b] = v.pt_head[8*(8-b) +: 8];
    end else if (v.new_pt) begin
      for (int k = 0; k < MSG_LEN; k++) p_mem[k] = 8'($urandom);
    end else begin
      for (int k = 0; k < MSG_LEN; k++) p_mem[k] = p_mem[k];
    end
  endtask

  initial begin
    int e0, e1, dcyc, wc0, ws0, same;
    logic [23:0] k1, k2;

    tbl[0] = '{24'h4B6579, 1'b0, 1'b1, 72'h506C61696E74657874, 72'hBBF316E8D940AF0AD3};
    tbl[1] = '{24'h000123, 1'b1, 1'b0, 72'h0, 72'h0};
    tbl[2] = '{24'hFFFFFF, 1'b1, 1'b0, 72'h0, 72'h0};
    tbl[3] = '{24'h3FFFFF, 1'b0, 1'b0, 72'h0, 72'h0};
    tbl[4] = '{24'($urandom), 1'b1, 1'b0, 72'h0, 72'h0};

    #3 rst = 1'b0;
    #2;
    check("reset_outputs", longint'({busy, done, wren_s, wren_c, address_s, data_s,
                                     address_p, address_c, data_c}), 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_without_start", longint'({busy, done, wren_s, wren_c}), 0);

    for (int v = 0; v < 5; v++) begin
      load_pt(tbl[v]);
      run_full(tbl[v].key, 1'b1);
      if (tbl[v].kat) check_kat(tbl[v].ct_head);
      if (v == 2) for (int k = 0; k < MSG_LEN; k++) prev_ct[k] = int'(c_mem[k]);
      if (v == 3) begin
        same = 0;
        for (int k = 0; k < MSG_LEN; k++) if (int'(c_mem[k]) == prev_ct[k]) same++;
`ifdef RC4_ENC_KEY_MASK_EN
        check("key_mask_same_ct", longint'(same), MSG_LEN);
`else
        check("key_unmasked_ct_differs", longint'(same == MSG_LEN), 0);
`endif
      end
    end

    // Reset in the middle of the key schedule, then a clean known-answer run.
    load_pt(tbl[0]);
    accept(24'h4B6579, e0);
    start = 1'b0;
    for (int w = 0; w < 800 && cyc < e0 + 700; w++) @(negedge clk);
    check("busy_before_reset", longint'(busy), 1);
    #2 rst = 1'b0;
    #1;
    check("outputs_in_mid_reset", longint'({busy, done, wren_s, wren_c, address_s, data_s,
                                            address_p, address_c, data_c}), 0);
    @(negedge clk);
    rst = 1'b1;
    run_full(24'h4B6579, 1'b0);
    check_kat(tbl[0].ct_head);

    // start held high: back-to-back runs, each with the key present at its own accept.
    for (int k = 0; k < MSG_LEN; k++) p_mem[k] = 8'($urandom);
    k1 = 24'($urandom);
    k2 = 24'($urandom);
    wc0 = wc_total;
    ws0 = ws_total;
    model_run(k1);
    accept(k1, e0);
    secret_key = k2;
    wait_done(e0, 1'b0, dcyc);
    @(negedge clk);
    check("hold_done_one_cycle", longint'(done), 0);
    verify(wc0, ws0);
    wc0 = wc_total;
    ws0 = ws_total;
    @(negedge clk);
    e1 = cyc;
    check("hold_reaccept_period", longint'(e1 - e0), T_DONE + 2);
    check("hold_busy_second", longint'(busy), 1);
    model_run(k2);
    wait_done(e1, 1'b0, dcyc);
    start = 1'b0;
    @(negedge clk);
    verify(wc0, ws0);
    repeat (3) @(negedge clk);
    check("hold_released_idle", longint'(busy), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
